// File: rtl/reg_bank_shadow.sv
// Shadowed register bank: per-channel staging registers that are atomically
// transferred to the active outputs on a commit, with a dirty mask and commit counter.

module reg_bank_shadow_lane #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             apply,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             dirty
);
  logic [WIDTH-1:0] stage;

  // On a commit with a simultaneous write, the pre-write staging value is
  // committed and the fresh write stays pending (dirty remains set).
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= RESET_VAL;
      q     <= RESET_VAL;
      dirty <= 1'b0;
    end else if (clr) begin
      stage <= RESET_VAL;
      dirty <= 1'b0;
    end else begin
      if (apply && dirty) q <= stage;
      if (wr_en) begin
        stage <= wr_data;
        dirty <= 1'b1;
      end else if (apply) begin
        dirty <= 1'b0;
      end
    end
  end
endmodule

module reg_bank_shadow #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       wr_en,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  input  logic                      commit,
  input  logic                      clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      commit_done,
  output logic [CNT_W-1:0]          upd_cnt
);
  logic apply;

  // A commit only counts when something is pending and no clear is requested.
  assign apply = commit && !clr && (|dirty);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    reg_bank_shadow_lane #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data (wr_data[i*WIDTH +: WIDTH]),
      .apply   (apply),
      .clr     (clr),
      .q       (q[i*WIDTH +: WIDTH]),
      .dirty   (dirty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_done <= 1'b0;
      upd_cnt     <= '0;
    end else begin
      commit_done <= apply;
      if (apply) upd_cnt <= upd_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_reg_bank_shadow.sv
// Directed + random bench for reg_bank_shadow with a scoreboard of expected outputs.

module tb_reg_bank_shadow;
  logic        clk = 1'b0;
  logic        rst, commit, clr;
  logic [2:0]  wr_en;
  logic [23:0] wr_data;
  logic [23:0] q, q2;
  logic [2:0]  dirty, dirty2;
  logic        commit_done, commit_done2;
  logic [7:0]  upd_cnt;
  logic [1:0]  upd_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [23:0] q;
    logic [2:0]  dirty;
    logic        done;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  m_stage [3];
  logic [23:0] m_q;
  logic [2:0]  m_dirty;
  logic        m_done;
  logic [7:0]  m_cnt;
  logic [1:0]  m_cnt2;

  always #5 clk = ~clk;

  reg_bank_shadow dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .commit(commit), .clr(clr),
    .q(q), .dirty(dirty), .commit_done(commit_done), .upd_cnt(upd_cnt)
  );

  reg_bank_shadow #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .commit(commit), .clr(clr),
    .q(q2), .dirty(dirty2), .commit_done(commit_done2), .upd_cnt(upd_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: computes the state expected after the next edge.
  task automatic model(input logic r, input logic [2:0] we, input logic [23:0] d,
                       input logic c, input logic cl);
    logic ap;
    if (r) begin
      for (int i = 0; i < 3; i++) m_stage[i] = 8'h00;
      m_q = '0; m_dirty = '0; m_done = 1'b0; m_cnt = '0; m_cnt2 = '0;
    end else if (cl) begin
      for (int i = 0; i < 3; i++) m_stage[i] = 8'h00;
      m_dirty = '0; m_done = 1'b0;
    end else begin
      ap = c && (m_dirty != 3'b000);
      for (int i = 0; i < 3; i++) begin
        if (ap && m_dirty[i]) m_q[i*8 +: 8] = m_stage[i];
        if (we[i]) begin
          m_stage[i] = d[i*8 +: 8];
          m_dirty[i] = 1'b1;
        end else if (ap) begin
          m_dirty[i] = 1'b0;
        end
      end
      m_done = ap;
      if (ap) begin
        m_cnt  = m_cnt + 8'd1;
        m_cnt2 = m_cnt2 + 2'd1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] we, input logic [23:0] d,
                      input logic c, input logic cl);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_data = d; commit = c; clr = cl;
    model(r, we, d, c, cl);
    e.q = m_q; e.dirty = m_dirty; e.done = m_done; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("dirty", 32'(dirty), 32'(e.dirty));
      chk("commit_done", 32'(commit_done), 32'(e.done));
      chk("upd_cnt", 32'(upd_cnt), 32'(e.cnt));
      chk("upd_cnt_w2", 32'(upd_cnt2), 32'(e.cnt2));
      chk("q_w2", 32'(q2), 32'(e.q));
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = '0; wr_data = '0; commit = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) m_stage[i] = 8'h00;
    m_q = '0; m_dirty = '0; m_done = 1'b0; m_cnt = '0; m_cnt2 = '0;

    // reset wins over writes and commit
    step(1, 3'b111, 24'hABCDEF, 1, 0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    chk("rst_done", 32'(commit_done), 32'h0);
    chk("rst_cnt", 32'(upd_cnt), 32'h0);
    step(0, 3'b000, 24'h0, 0, 0);

    // stage ch0/ch2 then commit
    step(0, 3'b101, 24'hC3_77_5A, 0, 0);
    chk("wr_dirty", 32'(dirty), 32'h5);
    chk("wr_q", 32'(q), 32'h0);
    step(0, 3'b000, 24'h0, 1, 0);
    chk("cm_q", 32'(q), 32'hC3005A);
    chk("cm_dirty", 32'(dirty), 32'h0);
    chk("cm_done", 32'(commit_done), 32'h1);
    chk("cm_cnt", 32'(upd_cnt), 32'h1);
    step(0, 3'b000, 24'h0, 0, 0);
    chk("cm_done_pulse", 32'(commit_done), 32'h0);

    // commit with nothing dirty
    step(0, 3'b000, 24'h0, 1, 0);
    chk("nop_done", 32'(commit_done), 32'h0);
    chk("nop_cnt", 32'(upd_cnt), 32'h1);
    chk("nop_q", 32'(q), 32'hC3005A);

    // write and commit colliding on ch1
    step(0, 3'b010, 24'h00_11_00, 0, 0);
    step(0, 3'b010, 24'h00_22_00, 1, 0);
    chk("col_q", 32'(q), 32'hC3115A);
    chk("col_dirty", 32'(dirty), 32'h2);
    step(0, 3'b000, 24'h0, 1, 0);
    chk("col2_q", 32'(q), 32'hC3225A);
    chk("col2_dirty", 32'(dirty), 32'h0);
    chk("col2_cnt", 32'(upd_cnt), 32'h3);
    chk("col2_done", 32'(commit_done), 32'h1);

    // clear overrides commit and writes
    step(0, 3'b111, 24'h99_88_77, 0, 0);
    step(0, 3'b111, 24'h12_34_56, 1, 1);
    chk("clr_dirty", 32'(dirty), 32'h0);
    chk("clr_q", 32'(q), 32'hC3225A);
    chk("clr_done", 32'(commit_done), 32'h0);
    chk("clr_cnt", 32'(upd_cnt), 32'h3);
    step(0, 3'b000, 24'h0, 1, 0);
    chk("clr_then_cm_q", 32'(q), 32'hC3225A);

    // back-to-back applied commits
    step(0, 3'b001, 24'h00_00_01, 0, 0);
    step(0, 3'b001, 24'h00_00_02, 1, 0);
    step(0, 3'b000, 24'h0, 1, 0);
    chk("b2b_done", 32'(commit_done), 32'h1);
    chk("b2b_q", 32'(q), 32'hC32202);

    // pending commit discarded by reset
    step(0, 3'b100, 24'hEE_00_00, 0, 0);
    step(1, 3'b000, 24'h0, 1, 0);
    chk("rst2_q", 32'(q), 32'h0);
    chk("rst2_cnt", 32'(upd_cnt), 32'h0);

    // 2-bit counter wrap
    step(0, 3'b001, 24'h00_00_10, 0, 0);
    step(0, 3'b001, 24'h00_00_11, 1, 0);
    chk("wrap1", 32'(upd_cnt2), 32'h1);
    step(0, 3'b001, 24'h00_00_12, 1, 0);
    chk("wrap2", 32'(upd_cnt2), 32'h2);
    step(0, 3'b001, 24'h00_00_13, 1, 0);
    chk("wrap3", 32'(upd_cnt2), 32'h3);
    step(0, 3'b000, 24'h0, 1, 0);
    chk("wrap0", 32'(upd_cnt2), 32'h0);
    chk("wrap_cnt8", 32'(upd_cnt), 32'h4);

    // random traffic against the model
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 39) == 0), 3'($urandom), 24'($urandom),
           1'($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
